// File: rtl/lift_pkg.sv
// Shared definitions for the lift hall-call scheduler: request codes,
// call-bit/code mapping helpers and the sequencer state type.
package lift_pkg;

    localparam logic [2:0] CodeNone = 3'b000;
    localparam logic [2:0] Code1U   = 3'b001;
    localparam logic [2:0] Code2U   = 3'b010;
    localparam logic [2:0] Code3U   = 3'b011;
    localparam logic [2:0] Code4D   = 3'b100;
    localparam logic [2:0] Code2D   = 3'b110;
    localparam logic [2:0] Code3D   = 3'b111;

    localparam logic [1:0] DirStay = 2'b00;
    localparam logic [1:0] DirUp   = 2'b01;
    localparam logic [1:0] DirDown = 2'b10;

    localparam int unsigned NumCalls = 6;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } seq_state_e;

    function automatic logic [2:0] call_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = Code1U;
            3'd1:    code = Code2U;
            3'd2:    code = Code3U;
            3'd3:    code = Code2D;
            3'd4:    code = Code3D;
            3'd5:    code = Code4D;
            default: code = CodeNone;
        endcase
        return code;
    endfunction

    function automatic logic [5:0] code_mask(input logic [2:0] code);
        logic [5:0] mask;
        case (code)
            Code1U:  mask = 6'b000001;
            Code2U:  mask = 6'b000010;
            Code3U:  mask = 6'b000100;
            Code2D:  mask = 6'b001000;
            Code3D:  mask = 6'b010000;
            Code4D:  mask = 6'b100000;
            default: mask = 6'b000000;
        endcase
        return mask;
    endfunction

    // Lowest set index wins so simultaneous presses enter the FIFO bit0 first.
    function automatic logic [2:0] lowest_idx(input logic [5:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lift_call_fifo.sv
// Six-entry, 3-bit circular FIFO holding request codes in arrival order.
// Pointers wrap modulo 6.
module lift_call_fifo
    import lift_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [2:0] push_data,
    input  logic       pop,
    output logic [2:0] head,
    output logic [2:0] count
);

    logic [2:0] mem_q [NumCalls];
    logic [2:0] wptr_q;
    logic [2:0] rptr_q;
    logic [2:0] count_q;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : p + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            count_q <= 3'd0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == 3'd6));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == 3'd0));

endmodule

// File: rtl/lift_call_scheduler.sv
// Captures and dedups hall calls, serialises them into a FIFO and issues
// them one at a time to the lift FSM, paced by fsm_done.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] call,
    input  logic       fsm_done,
    output logic [2:0] fsm_din,
    output logic       fsm_qempty,
    output logic [5:0] pending,
    output logic [2:0] q_count,
    output logic       issue
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_state_e      state_q, state_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [5:0]      arrived_q, arrived_d;
    logic [5:0]      pending_q, pending_d;
    logic [2:0]      din_q, din_d;
    logic            issue_q, issue_d;
    logic            qempty_q, qempty_d;

    logic            push, pop;
    logic [2:0]      push_idx;
    logic [5:0]      push_mask, pop_mask, accept;
    logic [2:0]      head, count, count_d;

    lift_call_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (call_code(push_idx)),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        pop       = (state_q == StIssue);
        pop_mask  = pop ? code_mask(head) : 6'b0;
        // A code popped this edge is free again, so a re-press is a fresh call.
        accept    = call & (~pending_q | pop_mask);
        push      = |arrived_q;
        push_idx  = lowest_idx(arrived_q);
        push_mask = push ? (6'b000001 << push_idx) : 6'b0;
        arrived_d = (arrived_q & ~push_mask) | accept;
        pending_d = (pending_q & ~pop_mask) | accept;
        count_d   = count + 3'(push) - 3'(pop);

        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (count != 3'd0 && fsm_done) state_d = StIssue;
            end
            StIssue: begin
                state_d   = StGap;
                gap_cnt_d = GapW'(GAP_CYCLES - 1);
            end
            StGap: begin
                if (gap_cnt_q == '0) state_d = StIdle;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Head is stable across the IDLE->ISSUE edge since no pop happens there.
        issue_d  = (state_d == StIssue);
        din_d    = issue_d ? head : CodeNone;
        qempty_d = (count_d == 3'd0) && (arrived_d == 6'b0) && (state_d != StIssue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            arrived_q <= 6'b0;
            pending_q <= 6'b0;
            din_q     <= CodeNone;
            issue_q   <= 1'b0;
            qempty_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            arrived_q <= arrived_d;
            pending_q <= pending_d;
            din_q     <= din_d;
            issue_q   <= issue_d;
            qempty_q  <= qempty_d;
        end
    end

    assign fsm_din    = din_q;
    assign fsm_qempty = qempty_q;
    assign pending    = pending_q;
    assign q_count    = count;
    assign issue      = issue_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboard bench for lift_call_scheduler: expected issue codes are queued
// as calls are driven and popped whenever the DUT raises issue.
module tb_lift_call_scheduler;

    localparam int unsigned Gap = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] call = 6'b0;
    logic       fsm_done = 1'b1;
    logic [2:0] fsm_din;
    logic       fsm_qempty;
    logic [5:0] pending;
    logic [2:0] q_count;
    logic       issue;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned since_issue = 1000;
    int unsigned max_count = 0;
    logic [2:0]  exp_q [$];

    lift_call_scheduler #(.GAP_CYCLES(Gap)) dut (
        .clk        (clk),
        .rst        (rst),
        .call       (call),
        .fsm_done   (fsm_done),
        .fsm_din    (fsm_din),
        .fsm_qempty (fsm_qempty),
        .pending    (pending),
        .q_count    (q_count),
        .issue      (issue)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check_eq("drain_in_time", n < 300, 1);
        repeat (Gap + 4) tick();
    endtask

    // Scoreboard side: every issue cycle must match the next expected code.
    always @(negedge clk) begin
        if (issue) begin
            if (exp_q.size() == 0) check_eq("unexpected_issue", 1, 0);
            else                   check_eq("issue_code", fsm_din, exp_q.pop_front());
            check_eq("issue_spacing", since_issue > Gap, 1);
            since_issue = 0;
        end else begin
            since_issue++;
        end
        if (rst) since_issue = 1000;
        if (q_count > max_count) max_count = q_count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every call held.
        call = 6'h3F;
        repeat (3) tick();
        check_eq("rst_din", fsm_din, 0);
        check_eq("rst_qempty", fsm_qempty, 1);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_qcount", q_count, 0);
        check_eq("rst_issue", issue, 0);
        rst = 1'b0;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b011);
        exp_q.push_back(3'b110); exp_q.push_back(3'b111); exp_q.push_back(3'b100);
        tick();
        call = 6'b0;
        check_eq("all_pending", pending, 6'h3F);
        drain();
        check_eq("all_done_pending", pending, 0);
        check_eq("all_done_qempty", fsm_qempty, 1);

        // Single 3U call latency.
        call = 6'b000100;
        exp_q.push_back(3'b011);
        tick();
        call = 6'b0;
        check_eq("lat_e0_pending", pending, 6'b000100);
        check_eq("lat_e0_qempty", fsm_qempty, 0);
        check_eq("lat_e0_din", fsm_din, 0);
        tick();
        check_eq("lat_e1_qcount", q_count, 1);
        check_eq("lat_e1_din", fsm_din, 0);
        tick();
        check_eq("lat_e2_din", fsm_din, 3'b011);
        check_eq("lat_e2_issue", issue, 1);
        tick();
        check_eq("lat_e3_din", fsm_din, 0);
        check_eq("lat_e3_issue", issue, 0);
        check_eq("lat_e3_pending", pending, 0);
        check_eq("lat_e3_qempty", fsm_qempty, 1);
        drain();

        // Duplicate 2U press while pending.
        fsm_done = 1'b0;
        call = 6'b000010;
        exp_q.push_back(3'b010);
        tick();
        call = 6'b0;
        tick();
        check_eq("dup_qcount1", q_count, 1);
        call = 6'b000010;
        tick();
        call = 6'b0;
        repeat (2) tick();
        check_eq("dup_qcount_after", q_count, 1);
        check_eq("dup_pending", pending, 6'b000010);
        fsm_done = 1'b1;
        drain();

        // Hold done low, queue 4D then 1U.
        fsm_done = 1'b0;
        call = 6'b100000;
        exp_q.push_back(3'b100);
        tick();
        call = 6'b000001;
        exp_q.push_back(3'b001);
        tick();
        call = 6'b0;
        repeat (4) tick();
        check_eq("hold_qcount", q_count, 2);
        check_eq("hold_din", fsm_din, 0);
        check_eq("hold_qempty", fsm_qempty, 0);
        check_eq("hold_noissue", exp_q.size(), 2);
        fsm_done = 1'b1;
        drain();

        // Reset in the middle of an ISSUE cycle with three queued.
        fsm_done = 1'b0;
        call = 6'b000111;
        tick();
        call = 6'b0;
        repeat (3) tick();
        check_eq("midrst_qcount", q_count, 3);
        exp_q.push_back(3'b001);
        fsm_done = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (issue) break;
        end
        check_eq("midrst_in_issue", issue, 1);
        rst = 1'b1;
        tick();
        check_eq("midrst_din", fsm_din, 0);
        check_eq("midrst_qcount0", q_count, 0);
        check_eq("midrst_pending", pending, 0);
        check_eq("midrst_qempty", fsm_qempty, 1);
        check_eq("midrst_issue", issue, 0);
        rst = 1'b0;
        repeat (15) tick();
        check_eq("midrst_discarded", exp_q.size(), 0);

        // Advance pointers by three, then fill all six across the wrap.
        call = 6'b111000;
        exp_q.push_back(3'b110); exp_q.push_back(3'b111); exp_q.push_back(3'b100);
        tick();
        call = 6'b0;
        drain();
        fsm_done = 1'b0;
        call = 6'h3F;
        exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b011);
        exp_q.push_back(3'b110); exp_q.push_back(3'b111); exp_q.push_back(3'b100);
        tick();
        call = 6'b0;
        repeat (7) tick();
        check_eq("wrap_full", q_count, 6);
        check_eq("wrap_pending", pending, 6'h3F);
        call = 6'h3F;
        tick();
        call = 6'b0;
        tick();
        check_eq("wrap_full_dedup", q_count, 6);
        fsm_done = 1'b1;
        drain();
        check_eq("wrap_empty", q_count, 0);
        check_eq("max_count_le6", max_count <= 6, 1);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
